// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and default widths for the bus arbiter slice
//
// Purpose: arbiter state encoding and the default address/tag widths used by
//          bus_arbiter, bus_decoder and bus_rr_pick.
// Ports:   none (package).

package bus_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_TAG_WIDTH  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } bus_state_t;

endpackage

// File: rtl/bus_decoder.sv
// rtl/bus_decoder.sv - splits the target tag out of an address and masks it off
//
// Purpose: the target tag is the low TagWidth bits of the upper MaskWidth
//          address bits; the target sees the address with those MaskWidth
//          bits cleared.
// Ports:   addr        in  AddrWidth  full bus address
//          masked_addr out AddrWidth  address with upper MaskWidth bits zeroed
//          tag         out TagWidth   target index

module bus_decoder
    import bus_pkg::*;
#(
    parameter int AddrWidth = DEF_ADDR_WIDTH,
    parameter int TagWidth  = DEF_TAG_WIDTH,
    parameter int MaskWidth = 4
) (
    input  logic [AddrWidth-1:0] addr,
    output logic [AddrWidth-1:0] masked_addr,
    output logic [TagWidth-1:0]  tag
);

    localparam logic [AddrWidth-1:0] KeepMask = {{MaskWidth{1'b0}}, {(AddrWidth-MaskWidth){1'b1}}};

    assign tag         = addr[AddrWidth-MaskWidth +: TagWidth];
    assign masked_addr = addr & KeepMask;

endmodule

// File: rtl/bus_rr_pick.sv
// rtl/bus_rr_pick.sv - combinational round-robin request picker
//
// Purpose: searches the request vector starting one past last_grant,
//          wrapping modulo NumMasters, and returns the first requester.
// Ports:   req        in  NumMasters  request vector
//          last_grant in  IdxWidth    index granted most recently
//          winner     out IdxWidth    chosen index (0 when valid is low)
//          valid      out 1           at least one request is high

module bus_rr_pick #(
    parameter int NumMasters = 2,
    parameter int IdxWidth   = $clog2(NumMasters)
) (
    input  logic [NumMasters-1:0] req,
    input  logic [IdxWidth-1:0]   last_grant,
    output logic [IdxWidth-1:0]   winner,
    output logic                  valid
);

    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        valid  = 1'b0;
        // i runs 1..NumMasters so the previous winner is considered last.
        for (int i = 1; i <= NumMasters; i++) begin
            idx = (int'(last_grant) + i) % NumMasters;
            if (!valid && req[idx]) begin
                winner = IdxWidth'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin shared bus arbiter with per-access timeout
//
// Purpose: grants one master at a time, latches its request, routes it to the
//          target chosen by the address tag and returns ack/err/rdata.
//          A silent target is converted into an error after TimeoutCycles.
// Ports:   clk, reset                   clock, synchronous active-high reset
//          m_req/m_addr/m_we/m_wdata/m_wstrb   per-master request fields
//          m_ack (per master), m_err, m_rdata  completion back to masters
//          s_sel/s_addr/s_we/s_wdata/s_wstrb   request to targets
//          s_ack, s_rdata (per target)         target completion

module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NumMasters    = 2,
    parameter int TagWidth      = DEF_TAG_WIDTH,
    parameter int MaskWidth     = 4,
    parameter int AddrWidth     = DEF_ADDR_WIDTH,
    parameter int TimeoutCycles = 255
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NumMasters-1:0]                  m_req,
    input  logic [NumMasters-1:0][AddrWidth-1:0]   m_addr,
    input  logic [NumMasters-1:0]                  m_we,
    input  logic [NumMasters-1:0][AddrWidth-1:0]   m_wdata,
    input  logic [NumMasters-1:0][AddrWidth/8-1:0] m_wstrb,
    output logic [NumMasters-1:0]                  m_ack,
    output logic                                   m_err,
    output logic [AddrWidth-1:0]                   m_rdata,
    output logic [2**TagWidth-1:0]                 s_sel,
    output logic [AddrWidth-1:0]                   s_addr,
    output logic                                   s_we,
    output logic [AddrWidth-1:0]                   s_wdata,
    output logic [AddrWidth/8-1:0]                 s_wstrb,
    input  logic [2**TagWidth-1:0]                 s_ack,
    input  logic [2**TagWidth-1:0][AddrWidth-1:0]  s_rdata
);

    localparam int IdxWidth   = $clog2(NumMasters);
    localparam int NumTargets = 2**TagWidth;
    localparam int StrbWidth  = AddrWidth/8;
    localparam int CntWidth   = $clog2(TimeoutCycles+1);
    localparam logic [CntWidth-1:0] Limit = CntWidth'(TimeoutCycles);

    bus_state_t             state;
    logic [IdxWidth-1:0]    last_grant;
    logic [IdxWidth-1:0]    winner_q;
    logic [AddrWidth-1:0]   addr_q;
    logic                   we_q;
    logic [AddrWidth-1:0]   wdata_q;
    logic [StrbWidth-1:0]   wstrb_q;
    logic [CntWidth-1:0]    cnt;

    logic [IdxWidth-1:0]    pick;
    logic                   pick_valid;
    logic [TagWidth-1:0]    tag;

    bus_rr_pick #(
        .NumMasters (NumMasters),
        .IdxWidth   (IdxWidth)
    ) u_pick (
        .req        (m_req),
        .last_grant (last_grant),
        .winner     (pick),
        .valid      (pick_valid)
    );

    bus_decoder #(
        .AddrWidth   (AddrWidth),
        .TagWidth    (TagWidth),
        .MaskWidth   (MaskWidth)
    ) u_dec (
        .addr        (addr_q),
        .masked_addr (s_addr),
        .tag         (tag)
    );

    // Target-side outputs are decoded only from registers (state and the
    // latched request), so master inputs never reach the targets directly.
    assign s_sel   = (state == ST_ACCESS) ? (NumTargets'(1) << tag) : '0;
    assign s_we    = we_q;
    assign s_wdata = wdata_q;
    assign s_wstrb = wstrb_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_grant <= IdxWidth'(NumMasters-1);
            winner_q   <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            cnt        <= '0;
            m_ack      <= '0;
            m_err      <= 1'b0;
            m_rdata    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    m_ack <= '0;
                    m_err <= 1'b0;
                    if (pick_valid) begin
                        winner_q <= pick;
                        addr_q   <= m_addr[pick];
                        we_q     <= m_we[pick];
                        wdata_q  <= m_wdata[pick];
                        wstrb_q  <= m_wstrb[pick];
                        cnt      <= '0;
                        state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // Ack is tested first so an ack on the limit cycle wins.
                    if (s_ack[tag]) begin
                        m_rdata <= s_rdata[tag];
                        m_err   <= 1'b0;
                        m_ack   <= NumMasters'(1) << winner_q;
                        state   <= ST_DONE;
                    end else if (cnt == Limit) begin
                        m_rdata <= '0;
                        m_err   <= 1'b1;
                        m_ack   <= NumMasters'(1) << winner_q;
                        state   <= ST_DONE;
                    end else begin
                        // Never advances past Limit: the branch above leaves ACCESS first.
                        cnt <= cnt + CntWidth'(1);
                    end
                end
                ST_DONE: begin
                    m_ack      <= '0;
                    m_err      <= 1'b0;
                    last_grant <= winner_q;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter

module tb_bus_arbiter;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        m_req;
    logic [1:0][31:0]  m_addr;
    logic [1:0]        m_we;
    logic [1:0][31:0]  m_wdata;
    logic [1:0][3:0]   m_wstrb;
    logic [1:0]        m_ack;
    logic              m_err;
    logic [31:0]       m_rdata;
    logic [3:0]        s_sel;
    logic [31:0]       s_addr;
    logic              s_we;
    logic [31:0]       s_wdata;
    logic [3:0]        s_wstrb;
    logic [3:0]        s_ack;
    logic [3:0][31:0]  s_rdata;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(
        .NumMasters    (2),
        .TagWidth      (2),
        .MaskWidth     (4),
        .AddrWidth     (32),
        .TimeoutCycles (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .m_req   (m_req),
        .m_addr  (m_addr),
        .m_we    (m_we),
        .m_wdata (m_wdata),
        .m_wstrb (m_wstrb),
        .m_ack   (m_ack),
        .m_err   (m_err),
        .m_rdata (m_rdata),
        .s_sel   (s_sel),
        .s_addr  (s_addr),
        .s_we    (s_we),
        .s_wdata (s_wdata),
        .s_wstrb (s_wstrb),
        .s_ack   (s_ack),
        .s_rdata (s_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got no_finish want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        m_req = '0; m_addr = '0; m_we = '0; m_wdata = '0; m_wstrb = '0;
        s_ack = '0; s_rdata = '0;
        apply_reset();
        checks++;
        if ({m_ack, m_err, m_rdata, s_sel, s_addr, s_we, s_wdata, s_wstrb} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ack=%b err=%b rdata=%h sel=%b addr=%h we=%b wdata=%h wstrb=%b want all 0",
                     m_ack, m_err, m_rdata, s_sel, s_addr, s_we, s_wdata, s_wstrb);
        end
    endtask

    task automatic test_single_read();
        m_addr[0] = 32'h1000_0040; m_we[0] = 1'b0; m_req = 2'b01;
        tick();
        checks++;
        if (s_sel !== 4'b0010) begin errors++; $display("FAIL read_sel got %b want 0010", s_sel); end
        checks++;
        if (s_addr !== 32'h0000_0040) begin errors++; $display("FAIL read_addr got %h want 00000040", s_addr); end
        checks++;
        if (m_ack !== 2'b00) begin errors++; $display("FAIL read_early_ack got %b want 00", m_ack); end
        s_rdata[1] = 32'hDEAD_BEEF; s_ack = 4'b0010;
        tick();
        checks++;
        if (m_ack !== 2'b01 || m_err !== 1'b0 || m_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL read_done got ack=%b err=%b rdata=%h want ack=01 err=0 rdata=deadbeef", m_ack, m_err, m_rdata);
        end
        m_req = 2'b00; s_ack = 4'b0000;
        tick();
        checks++;
        if (m_ack !== 2'b00) begin errors++; $display("FAIL read_ack_pulse got %b want 00", m_ack); end
    endtask

    task automatic test_fairness();
        int w;
        apply_reset();
        m_addr[0] = 32'h1000_0040; m_addr[1] = 32'h2000_0008; m_we = 2'b00;
        s_rdata[1] = 32'hAAAA_0001; s_rdata[2] = 32'hBBBB_0002;
        s_ack = 4'b1111;
        m_req = 2'b11;
        for (int n = 0; n < 6; n++) begin
            w = 0;
            do begin
                tick();
                w++;
            end while (m_ack == 2'b00 && w < 10);
            checks++;
            if (m_ack !== (2'b01 << (n % 2))) begin
                errors++;
                $display("FAIL fair_grant_%0d got %b want %b", n, m_ack, 2'b01 << (n % 2));
            end
            checks++;
            if (m_rdata !== ((n % 2 == 0) ? 32'hAAAA_0001 : 32'hBBBB_0002)) begin
                errors++;
                $display("FAIL fair_rdata_%0d got %h want %h", n, m_rdata,
                         (n % 2 == 0) ? 32'hAAAA_0001 : 32'hBBBB_0002);
            end
            checks++;
            if (w !== ((n == 0) ? 2 : 3)) begin
                errors++;
                $display("FAIL fair_latency_%0d got %0d want %0d", n, w, (n == 0) ? 2 : 3);
            end
        end
        m_req = 2'b00; s_ack = 4'b0000;
        tick();
    endtask

    task automatic test_timeout();
        int cnt;
        int guard;
        m_addr[0] = 32'h1000_0000; m_we[0] = 1'b0;
        s_ack = 4'b1101;
        m_req = 2'b01;
        tick();
        cnt = 0;
        guard = 0;
        while (m_ack == 2'b00 && guard < 20) begin
            if (s_sel == 4'b0010) cnt++;
            tick();
            guard++;
        end
        checks++;
        if (cnt !== 5) begin errors++; $display("FAIL timeout_sel_cycles got %0d want 5", cnt); end
        checks++;
        if (m_ack !== 2'b01 || m_err !== 1'b1 || m_rdata !== 32'h0) begin
            errors++;
            $display("FAIL timeout_done got ack=%b err=%b rdata=%h want ack=01 err=1 rdata=0", m_ack, m_err, m_rdata);
        end
        m_req = 2'b00; s_ack = 4'b0000;
        tick();
    endtask

    task automatic test_ack_on_limit();
        m_addr[0] = 32'h1000_0010; m_we[0] = 1'b0;
        s_ack = 4'b0000;
        m_req = 2'b01;
        tick();
        repeat (4) tick();
        checks++;
        if (s_sel !== 4'b0010 || m_ack !== 2'b00) begin
            errors++;
            $display("FAIL limit_still_access got sel=%b ack=%b want sel=0010 ack=00", s_sel, m_ack);
        end
        s_rdata[1] = 32'hCAFE_F00D; s_ack = 4'b0010;
        tick();
        checks++;
        if (m_ack !== 2'b01 || m_err !== 1'b0 || m_rdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL limit_ack_wins got ack=%b err=%b rdata=%h want ack=01 err=0 rdata=cafef00d", m_ack, m_err, m_rdata);
        end
        m_req = 2'b00; s_ack = 4'b0000;
        tick();
    endtask

    task automatic test_write();
        m_addr[1] = 32'h3000_0100; m_we[1] = 1'b1; m_wdata[1] = 32'h1234_5678; m_wstrb[1] = 4'b0011;
        s_ack = 4'b0000; s_rdata[3] = 32'h5555_AAAA;
        m_req = 2'b10;
        tick();
        checks++;
        if (s_sel !== 4'b1000 || s_addr !== 32'h0000_0100 || s_we !== 1'b1 ||
            s_wdata !== 32'h1234_5678 || s_wstrb !== 4'b0011) begin
            errors++;
            $display("FAIL write_fields got sel=%b addr=%h we=%b wdata=%h wstrb=%b want 1000 00000100 1 12345678 0011",
                     s_sel, s_addr, s_we, s_wdata, s_wstrb);
        end
        m_wdata[1] = 32'hFFFF_FFFF; m_wstrb[1] = 4'b1111; m_we[1] = 1'b0; m_addr[1] = 32'h1000_0000;
        tick();
        checks++;
        if (s_sel !== 4'b1000 || s_we !== 1'b1 || s_wdata !== 32'h1234_5678 || s_wstrb !== 4'b0011) begin
            errors++;
            $display("FAIL write_stable got sel=%b we=%b wdata=%h wstrb=%b want 1000 1 12345678 0011",
                     s_sel, s_we, s_wdata, s_wstrb);
        end
        s_ack = 4'b1000;
        tick();
        checks++;
        if (m_ack !== 2'b10 || m_err !== 1'b0) begin
            errors++;
            $display("FAIL write_done got ack=%b err=%b want ack=10 err=0", m_ack, m_err);
        end
        m_req = 2'b00; s_ack = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid_access();
        logic seen_ack;
        m_addr[1] = 32'h2000_0044; m_we[1] = 1'b1; m_wdata[1] = 32'h0BAD_F00D; m_wstrb[1] = 4'b1111;
        s_ack = 4'b0000;
        m_req = 2'b10;
        tick();
        tick();
        checks++;
        if (s_sel !== 4'b0100) begin errors++; $display("FAIL mid_pre_sel got %b want 0100", s_sel); end
        reset = 1'b1; m_req = 2'b00;
        tick();
        checks++;
        if ({m_ack, m_err, m_rdata, s_sel, s_addr, s_we, s_wdata, s_wstrb} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got ack=%b err=%b rdata=%h sel=%b addr=%h we=%b wdata=%h wstrb=%b want all 0",
                     m_ack, m_err, m_rdata, s_sel, s_addr, s_we, s_wdata, s_wstrb);
        end
        reset = 1'b0;
        seen_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (m_ack !== 2'b00 || s_sel !== 4'b0000) seen_ack = 1'b1;
        end
        checks++;
        if (seen_ack !== 1'b0) begin errors++; $display("FAIL mid_no_late_ack got 1 want 0"); end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_single_read();
        test_fairness();
        test_timeout();
        test_ack_on_limit();
        test_write();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Shares one system bus between `NumMasters` requesters and routes each granted access to one of `2**TagWidth` targets. Target selection comes from the upper address tag, split out by an instantiated `bus_decoder`. Masters are granted round-robin, one transaction at a time. A per-access timeout turns a silent target into an error response, so no master can hang the bus.

## Interface
- `NumMasters`, default 2: number of requesters, at least 2.
- `TagWidth`, default 2: tag bits; number of targets is `2**TagWidth`.
- `MaskWidth`, default 4: upper address bits cleared on the target side; passed to `bus_decoder`.
- `AddrWidth`, default 32: address and data width.
- `TimeoutCycles`, default 255: maximum number of cycles to wait for a target ack.
- `clk` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `m_req` in `NumMasters`: per-master request. Held high until that master's `m_ack` is seen.
- `m_addr` in `NumMasters`×`AddrWidth`: per-master address.
- `m_we` in `NumMasters`: per-master write enable.
- `m_wdata` in `NumMasters`×`AddrWidth`: per-master write data.
- `m_wstrb` in `NumMasters`×`AddrWidth/8`: per-master byte strobes.
- `m_ack` out `NumMasters`: one-cycle completion pulse to the owning master.
- `m_err` out 1: valid with `m_ack`; 1 means timeout.
- `m_rdata` out `AddrWidth`: read data; valid with `m_ack` on reads.
- `s_sel` out `2**TagWidth`: one-hot target select.
- `s_addr` out `AddrWidth`: masked address.
- `s_we`, `s_wdata`, `s_wstrb` out: latched request fields.
- `s_ack` in `2**TagWidth`: per-target completion.
- `s_rdata` in `2**TagWidth`×`AddrWidth`: per-target read data.

## Operation
- **States.** IDLE, ACCESS and DONE.
- **IDLE.**
  - If any `m_req` is high, pick a winner round-robin, starting the search at `last_grant+1` and wrapping modulo `NumMasters`.
  - Latch the winner's index, addr, we, wdata and wstrb.
  - Clear the timeout counter and go to ACCESS.
  - If no request is high, stay in IDLE.
- **ACCESS.**
  - `s_sel[tag]` is high. `s_addr`, `s_we`, `s_wdata` and `s_wstrb` are driven from the latched fields.
  - When `s_ack[tag]` is high: capture `s_rdata[tag]` into `m_rdata`, set err=0, go to DONE.
  - Otherwise increment the counter. When the counter equals `TimeoutCycles` with no ack, set err=1, set `m_rdata`=0 and go to DONE.
  - `s_ack` from non-selected targets is ignored.
- **DONE.**
  - `m_ack[winner]`=1 and `m_err`=err, for exactly one cycle.
  - `last_grant` is set to the winner; next state is IDLE.
- **Master rule.** A master drops `m_req`, or presents its next request, on the edge where it samples `m_ack`.
- **Fields are captured once.** The latched fields do not change while in ACCESS, even if the master's inputs change.
- **Fairness.** If every master holds `m_req` continuously, grants rotate through all masters; no master is starved.
- **Counter width.** The timeout counter is `$clog2(TimeoutCycles+1)` bits and saturates; it never wraps.

## Timing
- **Reset values.** State=IDLE, `last_grant`=`NumMasters-1` (so master 0 has first priority). All outputs are 0: `m_ack`, `m_err`, `m_rdata`, `s_sel`, `s_addr`, `s_we`, `s_wdata`, `s_wstrb`.
- **Reset mid-transaction.** The cycle after `reset` is asserted, state is IDLE and `s_sel`=0. The abandoned master receives no `m_ack`.
- **Registered outputs.** All outputs are registered; there is no combinational path from master inputs to target outputs.
- **Latency.** Request sampled in IDLE at cycle 0; ACCESS starts at cycle 1. If `s_ack` arrives at cycle k ≥ 1, `m_ack` is high at cycle k+1. Best case: `m_ack` at cycle 2.
- **Timeout case.** `s_sel` stays high for `TimeoutCycles+1` cycles, then `m_ack` and `m_err` pulse.
- **Back-to-back.** There is at least one IDLE cycle between transactions; peak throughput is one access per 3 cycles.
- **Simultaneous ack and timeout.** If `s_ack` arrives on the cycle the counter hits its limit, the ack wins and err=0.

## Structure
- **Shared `bus_pkg`.** Holds the state enum (IDLE, ACCESS, DONE) and the default widths `AddrWidth` and `TagWidth`.
- **Reused `bus_decoder`.** Instantiated once on the latched address; it produces `s_addr` and the tag.
- **New sub-module `bus_rr_pick`.** Combinational round-robin picker. Inputs: request vector and `last_grant`. Outputs: winner index and `valid`.

## Test plan
- **Single read.** Master 0 reads 0x1000_0040 (tag 1 with defaults); target 1 acks in its first ACCESS cycle with rdata 0xDEAD_BEEF. Expect `s_sel`=0b0010, `s_addr`=0x0000_0040, and `m_ack[0]` with `m_rdata`=0xDEAD_BEEF at cycle 2, `m_err`=0.
- **Fairness.** Both masters hold `m_req` continuously for 6 transactions after reset. Grant order is 0,1,0,1,0,1.
- **Timeout.** `TimeoutCycles`=4 and the target never acks. `s_sel` stays high for 5 cycles, then `m_ack`=1, `m_err`=1, `m_rdata`=0.
- **Ack on the limit cycle.** `TimeoutCycles`=4 and the target acks on the 5th ACCESS cycle. Expect `m_err`=0 and the captured rdata.
- **Write.** Master 1 writes 0x1234_5678 with wstrb 0b0011 to tag 3. `s_we`=1, `s_wstrb`=0b0011 and `s_wdata` are stable through ACCESS, even when the master changes `m_wdata` mid-access.
- **Reset mid-access.** Assert `reset` in the 2nd ACCESS cycle. Next cycle: state IDLE, all outputs 0, and no `m_ack` ever appears for the abandoned request.
